// File: rtl/ahb2apb_wbuf_bridge.sv
// AHB-Lite to APB3 bridge with a posted-write FIFO, multi-slave PSEL decode and two-cycle ERROR responses.
// Define APB4_EN to add the PPROT/PSTRB outputs and store HSIZE/HPROT in the write buffer.
module ahb2apb_wbuf_bridge #(
  parameter int ADDRWIDTH  = 16,
  parameter int DATAWIDTH  = 32,
  parameter int WBUF_DEPTH = 4,
  parameter int NUM_SLAVES = 4,
  parameter int SLOT_LSB   = 12
) (
  input  logic                  HCLK,
  input  logic                  HRESET,
  input  logic                  HSEL,
  input  logic [ADDRWIDTH-1:0]  HADDR,
  input  logic [1:0]            HTRANS,
  input  logic                  HWRITE,
  input  logic [2:0]            HSIZE,
  input  logic [3:0]            HPROT,
  input  logic [DATAWIDTH-1:0]  HWDATA,
  input  logic                  HREADY,
  output logic                  HREADYOUT,
  output logic                  HRESP,
  output logic [DATAWIDTH-1:0]  HRDATA,
  input  logic                  PCLKEN,
  output logic [NUM_SLAVES-1:0] PSEL,
  output logic                  PENABLE,
  output logic [ADDRWIDTH-1:0]  PADDR,
  output logic                  PWRITE,
  output logic [DATAWIDTH-1:0]  PWDATA,
  input  logic [DATAWIDTH-1:0]  PRDATA,
  input  logic                  PREADY,
  input  logic                  PSLVERR,
  output logic                  WRERR,
  input  logic                  WRERR_CLR,
  output logic                  APBACTIVE
`ifdef APB4_EN
  ,
  output logic [2:0]            PPROT,
  output logic [3:0]            PSTRB
`endif
);

  localparam int PW = $clog2(WBUF_DEPTH);
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETUP  = 2'd1;
  localparam logic [1:0] ST_ACCESS = 2'd2;

  function automatic logic bad_slot(input logic [ADDRWIDTH-1:0] a);
    return {1'b0, a[SLOT_LSB+3:SLOT_LSB]} >= 5'(NUM_SLAVES);
  endfunction

`ifdef APB4_EN
  function automatic logic [3:0] strb_f(input logic [2:0] sz, input logic [1:0] a);
    case (sz)
      3'b000:  strb_f = 4'b0001 << a;
      3'b001:  strb_f = a[1] ? 4'b1100 : 4'b0011;
      default: strb_f = 4'b1111;
    endcase
  endfunction
`endif

  logic                 acc, push, pop, full, empty, wr_err_set;
  logic                 issue_wr, issue_rd, rd_done, rd_bad, unused_bits;
  logic                 dp_wr_q, dp_rd_q, rd_req_q, ok_q, err1_q, err2_q, wrerr_q;
  logic [1:0]           state_q, state_d;
  logic [PW:0]          wptr_q, rptr_q;
  logic [ADDRWIDTH-1:0] haddr_q, paddr_q, head_addr;
  logic [DATAWIDTH-1:0] pwdata_q, hrdata_q, head_data;
  logic                 pwrite_q;
  logic [ADDRWIDTH-1:0] fa_mem [WBUF_DEPTH];
  logic [DATAWIDTH-1:0] fd_mem [WBUF_DEPTH];
`ifdef APB4_EN
  logic [2:0]           hsize_q, pprot_q;
  logic [3:0]           hprot_q, pstrb_q;
  logic [2:0]           fs_mem [WBUF_DEPTH];
  logic [3:0]           fp_mem [WBUF_DEPTH];
`endif

  assign acc         = HSEL & HREADY & HTRANS[1];
  assign unused_bits = ^{HTRANS[0], HSIZE, HPROT};
  assign empty       = (wptr_q == rptr_q);
  assign full        = (wptr_q[PW] != rptr_q[PW]) && (wptr_q[PW-1:0] == rptr_q[PW-1:0]);
  assign head_addr   = fa_mem[rptr_q[PW-1:0]];
  assign head_data   = fd_mem[rptr_q[PW-1:0]];
  // A full buffer still accepts a write in the cycle an entry leaves it.
  assign push        = dp_wr_q & (~full | pop);

  // APB sequencing; every transition is qualified by PCLKEN.
  always_comb begin
    state_d    = state_q;
    pop        = 1'b0;
    wr_err_set = 1'b0;
    issue_wr   = 1'b0;
    issue_rd   = 1'b0;
    rd_done    = 1'b0;
    rd_bad     = 1'b0;
    if (PCLKEN) begin
      case (state_q)
        ST_IDLE: begin
          if (!empty) begin
            if (bad_slot(head_addr)) begin
              pop        = 1'b1;
              wr_err_set = 1'b1;
            end else begin
              issue_wr = 1'b1;
              state_d  = ST_SETUP;
            end
          end else if (rd_req_q) begin
            if (bad_slot(haddr_q)) rd_bad = 1'b1;
            else begin
              issue_rd = 1'b1;
              state_d  = ST_SETUP;
            end
          end
        end
        ST_SETUP: state_d = ST_ACCESS;
        ST_ACCESS: begin
          if (PREADY) begin
            state_d = ST_IDLE;
            if (pwrite_q) begin
              pop        = 1'b1;
              wr_err_set = PSLVERR;
            end else begin
              rd_done = 1'b1;
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      dp_wr_q  <= 1'b0;
      dp_rd_q  <= 1'b0;
      rd_req_q <= 1'b0;
      ok_q     <= 1'b0;
      err1_q   <= 1'b0;
      err2_q   <= 1'b0;
      wrerr_q  <= 1'b0;
      state_q  <= ST_IDLE;
      wptr_q   <= '0;
      rptr_q   <= '0;
      paddr_q  <= '0;
      pwdata_q <= '0;
      pwrite_q <= 1'b0;
      hrdata_q <= '0;
`ifdef APB4_EN
      pprot_q  <= '0;
      pstrb_q  <= '0;
`endif
    end else begin
      if (HREADY) begin
        dp_wr_q <= acc & HWRITE;
        dp_rd_q <= acc & ~HWRITE;
      end
      if (rd_done | rd_bad)             rd_req_q <= 1'b0;
      else if (HREADY & acc & ~HWRITE)  rd_req_q <= 1'b1;
      ok_q    <= rd_done & ~PSLVERR;
      err1_q  <= rd_bad | (rd_done & PSLVERR);
      err2_q  <= err1_q;
      wrerr_q <= wr_err_set ? 1'b1 : (WRERR_CLR ? 1'b0 : wrerr_q);
      state_q <= state_d;
      if (push) wptr_q <= wptr_q + (PW+1)'(1);
      if (pop)  rptr_q <= rptr_q + (PW+1)'(1);
      if (issue_wr) begin
        paddr_q  <= head_addr;
        pwdata_q <= head_data;
        pwrite_q <= 1'b1;
`ifdef APB4_EN
        pprot_q  <= {~fp_mem[rptr_q[PW-1:0]][0], fp_mem[rptr_q[PW-1:0]][1], fp_mem[rptr_q[PW-1:0]][2]};
        pstrb_q  <= strb_f(fs_mem[rptr_q[PW-1:0]], head_addr[1:0]);
`endif
      end else if (issue_rd) begin
        paddr_q  <= haddr_q;
        pwrite_q <= 1'b0;
`ifdef APB4_EN
        pprot_q  <= {~hprot_q[0], hprot_q[1], hprot_q[2]};
        pstrb_q  <= 4'b0000;
`endif
      end
      if (rd_done) hrdata_q <= PRDATA;
    end
  end

  // Address-phase capture and buffer storage carry no reset.
  always_ff @(posedge HCLK) begin
    if (HREADY & acc) begin
      haddr_q <= HADDR;
`ifdef APB4_EN
      hsize_q <= HSIZE;
      hprot_q <= HPROT;
`endif
    end
    if (push) begin
      fa_mem[wptr_q[PW-1:0]] <= haddr_q;
      fd_mem[wptr_q[PW-1:0]] <= HWDATA;
`ifdef APB4_EN
      fs_mem[wptr_q[PW-1:0]] <= hsize_q;
      fp_mem[wptr_q[PW-1:0]] <= hprot_q;
`endif
    end
  end

  always_comb begin
    PSEL = '0;
    for (int i = 0; i < NUM_SLAVES; i++)
      PSEL[i] = (state_q != ST_IDLE) && (paddr_q[SLOT_LSB+3:SLOT_LSB] == 4'(i));
  end

  assign HREADYOUT = dp_wr_q ? (~full | pop) : (dp_rd_q ? (ok_q | err2_q) : 1'b1);
  assign HRESP     = err1_q | err2_q;
  assign HRDATA    = hrdata_q;
  assign PENABLE   = (state_q == ST_ACCESS);
  assign PADDR     = paddr_q;
  assign PWRITE    = pwrite_q;
  assign PWDATA    = pwdata_q;
  assign WRERR     = wrerr_q;
  assign APBACTIVE = (state_q != ST_IDLE) | ~empty | rd_req_q;
`ifdef APB4_EN
  assign PPROT     = pprot_q;
  assign PSTRB     = pstrb_q;
`endif

endmodule

// File: tb/tb_ahb2apb_wbuf_bridge.sv
// Directed testbench for ahb2apb_wbuf_bridge (default build, APB4_EN undefined).
module tb_ahb2apb_wbuf_bridge;
  logic        HCLK = 1'b0;
  logic        HRESET, HSEL, HWRITE, HREADY, HREADYOUT, HRESP;
  logic [15:0] HADDR, PADDR;
  logic [1:0]  HTRANS;
  logic [2:0]  HSIZE;
  logic [3:0]  HPROT, PSEL;
  logic [31:0] HWDATA, HRDATA, PWDATA, PRDATA;
  logic        PCLKEN = 1'b1;
  logic        PENABLE, PWRITE, PREADY, PSLVERR, WRERR, WRERR_CLR, APBACTIVE;
  logic        div_mode = 1'b0;
  int          div_cnt = 0;
  int          checks = 0, errors = 0;

  logic [15:0] log_addr [64];
  logic [31:0] log_data [64];
  logic        log_wr   [64];
  logic [3:0]  log_sel  [64];
  int          log_n = 0;
  int          psel_cnt = 0;

  ahb2apb_wbuf_bridge dut (
    .HCLK(HCLK), .HRESET(HRESET), .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS),
    .HWRITE(HWRITE), .HSIZE(HSIZE), .HPROT(HPROT), .HWDATA(HWDATA), .HREADY(HREADY),
    .HREADYOUT(HREADYOUT), .HRESP(HRESP), .HRDATA(HRDATA), .PCLKEN(PCLKEN),
    .PSEL(PSEL), .PENABLE(PENABLE), .PADDR(PADDR), .PWRITE(PWRITE), .PWDATA(PWDATA),
    .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR), .WRERR(WRERR),
    .WRERR_CLR(WRERR_CLR), .APBACTIVE(APBACTIVE)
  );

  assign HREADY = HREADYOUT;
  always #5 HCLK = ~HCLK;

  always @(posedge HCLK) begin
    #2;
    if (div_mode) begin
      PCLKEN  = (div_cnt == 2);
      div_cnt = (div_cnt == 2) ? 0 : div_cnt + 1;
    end else begin
      PCLKEN  = 1'b1;
      div_cnt = 0;
    end
  end

  always @(posedge HCLK) begin
    if (!HRESET && PCLKEN && PENABLE && PREADY && log_n < 64) begin
      log_addr[log_n] = PADDR;
      log_data[log_n] = PWDATA;
      log_wr[log_n]   = PWRITE;
      log_sel[log_n]  = PSEL;
      log_n = log_n + 1;
    end
    if (|PSEL) psel_cnt = psel_cnt + 1;
  end

  task automatic tick;
    @(posedge HCLK);
    #1;
  endtask

  task automatic test_reset;
    HRESET = 1'b0; HSEL = 1'b0; HADDR = '0; HTRANS = 2'b00; HWRITE = 1'b0;
    HSIZE = 3'b010; HPROT = 4'b0011; HWDATA = '0; PRDATA = '0;
    PREADY = 1'b1; PSLVERR = 1'b0; WRERR_CLR = 1'b0;
    #2 HRESET = 1'b1;
    tick(); #3;
    checks++; if (HREADYOUT !== 1'b1) begin errors++; $display("FAIL rst_hreadyout got=%0h exp=1", HREADYOUT); end
    checks++; if (HRESP !== 1'b0) begin errors++; $display("FAIL rst_hresp got=%0h exp=0", HRESP); end
    checks++; if (PSEL !== 4'b0000) begin errors++; $display("FAIL rst_psel got=%0h exp=0", PSEL); end
    checks++; if (PENABLE !== 1'b0) begin errors++; $display("FAIL rst_penable got=%0h exp=0", PENABLE); end
    checks++; if (APBACTIVE !== 1'b0) begin errors++; $display("FAIL rst_apbactive got=%0h exp=0", APBACTIVE); end
    checks++; if (WRERR !== 1'b0) begin errors++; $display("FAIL rst_wrerr got=%0h exp=0", WRERR); end
    checks++; if (PADDR !== 16'h0 || PWDATA !== 32'h0 || HRDATA !== 32'h0) begin errors++; $display("FAIL rst_data paddr=%0h pwdata=%0h hrdata=%0h exp=0", PADDR, PWDATA, HRDATA); end
    tick();
    HRESET = 1'b0;
    HSEL = 1'b1;
    tick();
  endtask

  task automatic test_single_write;
    int base = log_n;
    HTRANS = 2'b10; HADDR = 16'h1004; HWRITE = 1'b1;
    #3;
    checks++; if (HREADYOUT !== 1'b1) begin errors++; $display("FAIL sw_addr_ready got=%0h exp=1", HREADYOUT); end
    tick();
    HTRANS = 2'b00; HWDATA = 32'hA5A5A5A5;
    #3;
    checks++; if (HREADYOUT !== 1'b1 || HRESP !== 1'b0) begin errors++; $display("FAIL sw_data_okay ready=%0h resp=%0h exp=1/0", HREADYOUT, HRESP); end
    tick(); #3;
    checks++; if (APBACTIVE !== 1'b1 || PSEL !== 4'b0000) begin errors++; $display("FAIL sw_buffered apbactive=%0h psel=%0h exp=1/0", APBACTIVE, PSEL); end
    tick(); #3;
    checks++; if (PSEL !== 4'b0010 || PENABLE !== 1'b0) begin errors++; $display("FAIL sw_setup psel=%0h pen=%0h exp=2/0", PSEL, PENABLE); end
    checks++; if (PADDR !== 16'h1004 || PWDATA !== 32'hA5A5A5A5 || PWRITE !== 1'b1) begin errors++; $display("FAIL sw_setup_bus paddr=%0h pwdata=%0h pwrite=%0h exp=1004/a5a5a5a5/1", PADDR, PWDATA, PWRITE); end
    tick(); #3;
    checks++; if (PSEL !== 4'b0010 || PENABLE !== 1'b1) begin errors++; $display("FAIL sw_access psel=%0h pen=%0h exp=2/1", PSEL, PENABLE); end
    tick(); #3;
    checks++; if (PSEL !== 4'b0000 || PENABLE !== 1'b0 || APBACTIVE !== 1'b0) begin errors++; $display("FAIL sw_done psel=%0h pen=%0h act=%0h exp=0/0/0", PSEL, PENABLE, APBACTIVE); end
    checks++; if (PWDATA !== 32'hA5A5A5A5) begin errors++; $display("FAIL sw_pwdata_hold got=%0h exp=a5a5a5a5", PWDATA); end
    checks++; if (log_n - base !== 1) begin errors++; $display("FAIL sw_count got=%0d exp=1", log_n - base); end
    tick();
  endtask

  task automatic test_back_to_back;
    logic [15:0] a [5] = '{16'h0100, 16'h1104, 16'h2208, 16'h330C, 16'h0410};
    logic [31:0] d [5] = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444, 32'h55555555};
    logic [3:0]  s [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    int base = log_n;
    int n = 0;
    PREADY = 1'b0;
    for (int k = 0; k < 5; k++) begin
      HTRANS = 2'b10; HADDR = a[k]; HWRITE = 1'b1;
      HWDATA = (k > 0) ? d[k-1] : 32'h0;
      #3;
      checks++; if (HREADYOUT !== 1'b1) begin errors++; $display("FAIL b2b_nowait_%0d got=%0h exp=1", k, HREADYOUT); end
      tick();
    end
    HTRANS = 2'b00; HWDATA = d[4];
    for (int j = 0; j < 3; j++) begin
      #3;
      checks++; if (HREADYOUT !== 1'b0) begin errors++; $display("FAIL b2b_full_stall_%0d got=%0h exp=0", j, HREADYOUT); end
      tick();
    end
    PREADY = 1'b1;
    #3;
    checks++; if (HREADYOUT !== 1'b1) begin errors++; $display("FAIL b2b_push_on_pop got=%0h exp=1", HREADYOUT); end
    tick();
    HWDATA = 32'h0;
    #3;
    while (APBACTIVE && n < 60) begin tick(); #3; n++; end
    checks++; if (APBACTIVE !== 1'b0) begin errors++; $display("FAIL b2b_drain_timeout apbactive=%0h exp=0", APBACTIVE); end
    checks++; if (log_n - base !== 5) begin errors++; $display("FAIL b2b_count got=%0d exp=5", log_n - base); end
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (log_addr[base+k] !== a[k] || log_data[base+k] !== d[k] || log_sel[base+k] !== s[k] || log_wr[base+k] !== 1'b1) begin
        errors++;
        $display("FAIL b2b_order_%0d got=%0h/%0h/%0h exp=%0h/%0h/%0h", k, log_addr[base+k], log_data[base+k], log_sel[base+k], a[k], d[k], s[k]);
      end
    end
    tick();
  endtask

  task automatic test_write_then_read;
    int base = log_n;
    int n = 0;
    PREADY = 1'b1; PRDATA = 32'h12345678;
    HTRANS = 2'b10; HADDR = 16'h0010; HWRITE = 1'b1;
    tick();
    HADDR = 16'h2000; HWRITE = 1'b0; HWDATA = 32'hCAFEF00D;
    #3;
    checks++; if (HREADYOUT !== 1'b1) begin errors++; $display("FAIL wr_rd_write_ready got=%0h exp=1", HREADYOUT); end
    tick();
    HTRANS = 2'b00;
    #3;
    while (!HREADYOUT && n < 30) begin tick(); #3; n++; end
    checks++; if (HREADYOUT !== 1'b1 || HRESP !== 1'b0) begin errors++; $display("FAIL wr_rd_complete ready=%0h resp=%0h exp=1/0", HREADYOUT, HRESP); end
    checks++; if (HRDATA !== 32'h12345678) begin errors++; $display("FAIL wr_rd_hrdata got=%0h exp=12345678", HRDATA); end
    checks++; if (log_n - base !== 2) begin errors++; $display("FAIL wr_rd_count got=%0d exp=2", log_n - base); end
    checks++; if (log_addr[base] !== 16'h0010 || log_wr[base] !== 1'b1 || log_data[base] !== 32'hCAFEF00D) begin errors++; $display("FAIL wr_rd_first got=%0h/%0h/%0h exp=10/1/cafef00d", log_addr[base], log_wr[base], log_data[base]); end
    checks++; if (log_addr[base+1] !== 16'h2000 || log_wr[base+1] !== 1'b0 || log_sel[base+1] !== 4'b0100) begin errors++; $display("FAIL wr_rd_second got=%0h/%0h/%0h exp=2000/0/4", log_addr[base+1], log_wr[base+1], log_sel[base+1]); end
    tick();
  endtask

  task automatic test_read_error;
    int n = 0;
    PREADY = 1'b1; PSLVERR = 1'b1; PRDATA = 32'h0;
    HTRANS = 2'b10; HADDR = 16'h3000; HWRITE = 1'b0;
    tick();
    HTRANS = 2'b00;
    #3;
    while (!HRESP && n < 30) begin tick(); #3; n++; end
    checks++; if (HRESP !== 1'b1 || HREADYOUT !== 1'b0) begin errors++; $display("FAIL rderr_cycle1 resp=%0h ready=%0h exp=1/0", HRESP, HREADYOUT); end
    tick(); #3;
    checks++; if (HRESP !== 1'b1 || HREADYOUT !== 1'b1) begin errors++; $display("FAIL rderr_cycle2 resp=%0h ready=%0h exp=1/1", HRESP, HREADYOUT); end
    PSLVERR = 1'b0;
    tick();
    PRDATA = 32'h55AA00FF;
    HTRANS = 2'b10; HADDR = 16'h1000;
    #3;
    checks++; if (HRESP !== 1'b0 || HREADYOUT !== 1'b1) begin errors++; $display("FAIL rderr_recover_idle resp=%0h ready=%0h exp=0/1", HRESP, HREADYOUT); end
    tick();
    HTRANS = 2'b00;
    n = 0;
    #3;
    while (!HREADYOUT && n < 30) begin tick(); #3; n++; end
    checks++; if (HREADYOUT !== 1'b1 || HRESP !== 1'b0 || HRDATA !== 32'h55AA00FF) begin errors++; $display("FAIL rderr_next_okay ready=%0h resp=%0h hrdata=%0h exp=1/0/55aa00ff", HREADYOUT, HRESP, HRDATA); end
    tick();
  endtask

  task automatic test_decode_error;
    int p0 = psel_cnt;
    int n = 0;
    HTRANS = 2'b10; HADDR = 16'h5000; HWRITE = 1'b1;
    tick();
    HTRANS = 2'b00; HWDATA = 32'hDEADBEEF;
    tick(); tick(); tick(); tick(); #3;
    checks++; if (WRERR !== 1'b1) begin errors++; $display("FAIL dec_wrerr_set got=%0h exp=1", WRERR); end
    checks++; if (psel_cnt !== p0 || APBACTIVE !== 1'b0) begin errors++; $display("FAIL dec_no_psel pselcycles=%0d act=%0h exp=0/0", psel_cnt - p0, APBACTIVE); end
    WRERR_CLR = 1'b1;
    tick();
    WRERR_CLR = 1'b0;
    #3;
    checks++; if (WRERR !== 1'b0) begin errors++; $display("FAIL dec_wrerr_clr got=%0h exp=0", WRERR); end
    tick();
    WRERR_CLR = 1'b1;
    HTRANS = 2'b10; HADDR = 16'h6000; HWRITE = 1'b1;
    tick();
    HTRANS = 2'b00;
    tick(); tick(); #3;
    checks++; if (WRERR !== 1'b1) begin errors++; $display("FAIL dec_set_wins got=%0h exp=1", WRERR); end
    tick(); #3;
    checks++; if (WRERR !== 1'b0) begin errors++; $display("FAIL dec_clr_after got=%0h exp=0", WRERR); end
    WRERR_CLR = 1'b0;
    HTRANS = 2'b10; HADDR = 16'h7000; HWRITE = 1'b0;
    tick();
    HTRANS = 2'b00;
    #3;
    while (!HRESP && n < 30) begin tick(); #3; n++; end
    checks++; if (HRESP !== 1'b1 || HREADYOUT !== 1'b0) begin errors++; $display("FAIL dec_rd_err1 resp=%0h ready=%0h exp=1/0", HRESP, HREADYOUT); end
    tick(); #3;
    checks++; if (HRESP !== 1'b1 || HREADYOUT !== 1'b1) begin errors++; $display("FAIL dec_rd_err2 resp=%0h ready=%0h exp=1/1", HRESP, HREADYOUT); end
    checks++; if (psel_cnt !== p0) begin errors++; $display("FAIL dec_rd_no_psel pselcycles=%0d exp=0", psel_cnt - p0); end
    tick();
  endtask

  task automatic test_pclken_reset;
    logic       pre_en;
    logic [1:0] pre_st;
    int n = 0;
    div_mode = 1'b1; PREADY = 1'b0;
    HTRANS = 2'b10; HADDR = 16'h1008; HWRITE = 1'b1;
    tick();
    HTRANS = 2'b00; HWDATA = 32'h00000077;
    tick();
    #3;
    while (!PENABLE && n < 40) begin
      pre_en = PCLKEN;
      pre_st = {PENABLE, |PSEL};
      tick(); #3; n++;
      if (!pre_en) begin
        checks++;
        if ({PENABLE, |PSEL} !== pre_st) begin errors++; $display("FAIL pclken_gated got=%0h exp=%0h", {PENABLE, |PSEL}, pre_st); end
      end
    end
    checks++; if (PENABLE !== 1'b1 || PSEL !== 4'b0010) begin errors++; $display("FAIL pclken_reach_access pen=%0h psel=%0h exp=1/2", PENABLE, PSEL); end
    tick(); tick();
    #1 HRESET = 1'b1;
    #1;
    checks++; if (PSEL !== 4'b0000 || PENABLE !== 1'b0) begin errors++; $display("FAIL arst_apb psel=%0h pen=%0h exp=0/0", PSEL, PENABLE); end
    checks++; if (HREADYOUT !== 1'b1 || HRESP !== 1'b0 || APBACTIVE !== 1'b0) begin errors++; $display("FAIL arst_ahb ready=%0h resp=%0h act=%0h exp=1/0/0", HREADYOUT, HRESP, APBACTIVE); end
    tick();
    HRESET = 1'b0; div_mode = 1'b0; PREADY = 1'b1;
    tick();
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_back_to_back();
    test_write_then_read();
    test_read_error();
    test_decode_error();
    test_pclken_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish got=timeout exp=finish");
    $fatal(1, "watchdog");
  end
endmodule
